// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128/192/256 key schedule, one word per cycle.
// Define AES_KEYEXP_DEC_EN to add rd_dec (reverse-order round key reads).

module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_load,
  output logic                busy,
  output logic                key_ready,
  input  logic [3:0]          rd_round,
`ifdef AES_KEYEXP_DEC_EN
  input  logic                rd_dec,
`endif
  output logic [127:0]        rd_key,
  output logic                rd_err
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK6   = 6'(NK);
  localparam logic [5:0] LAST6 = 6'(NW - 1);
  localparam logic [2:0] NKM1  = 3'(NK - 1);
  localparam logic [3:0] NR4   = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  mod_q, mod_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] words_q [NW];

  logic        load;
  logic        wr_en;
  logic [31:0] temp;
  logic [31:0] prev;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] new_word;
  logic        is_rcon;
  logic        is_sub8;

  assign temp    = words_q[idx_q - 6'd1];
  assign prev    = words_q[idx_q - NK6];
  assign is_rcon = (mod_q == 3'd0);
  assign is_sub8 = (NK == 8) && (mod_q == 3'd4);
  assign sub_in  = is_rcon ? {temp[23:0], temp[31:24]} : temp;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (sub_in[8*g +: 8]),
      .s_o (sub_out[8*g +: 8])
    );
  end

  // Next schedule word from w[i-NK] and w[i-1].
  always_comb begin
    new_word = prev ^ temp;
    unique case (1'b1)
      is_rcon: new_word = prev ^ sub_out ^ {rcon_q, 24'h0};
      is_sub8: new_word = prev ^ sub_out;
      default: new_word = prev ^ temp;
    endcase
  end

  // Next-state: any key_load restarts, EXPAND steps one word per cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mod_d   = mod_q;
    rcon_d  = rcon_q;
    load    = 1'b0;
    wr_en   = 1'b0;
    if (key_load) begin
      load    = 1'b1;
      state_d = S_EXPAND;
      idx_d   = NK6;
      mod_d   = 3'd0;
      rcon_d  = 8'h01;
    end else if (state_q == S_EXPAND) begin
      wr_en = 1'b1;
      mod_d = (mod_q == NKM1) ? 3'd0 : mod_q + 3'd1;
      if (is_rcon) begin
        rcon_d = xtime(rcon_q);
      end
      if (idx_q == LAST6) begin
        state_d = S_READY;
      end else begin
        idx_d = idx_q + 6'd1;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= NK6;
      mod_q   <= 3'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
    end
  end

  // Schedule storage: key capture on load, one word per expand cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        words_q[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < NK; k++) begin
        words_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
      end
    end else if (wr_en) begin
      words_q[idx_q] <= new_word;
    end
  end

  assign busy      = (state_q == S_EXPAND);
  assign key_ready = (state_q == S_READY);

  logic       rd_ok;
  logic [3:0] rd_sel;
  logic [5:0] rd_base;

  // Combinational read port; zero unless a complete schedule is held.
  always_comb begin
    rd_ok  = key_ready && (rd_round <= NR4);
    rd_sel = rd_round;
`ifdef AES_KEYEXP_DEC_EN
    if (rd_dec) begin
      rd_sel = NR4 - rd_round;
    end
`endif
    if (!rd_ok) begin
      rd_sel = 4'd0;
    end
    rd_base = {rd_sel, 2'b00};
    rd_key  = '0;
    if (rd_ok) begin
      rd_key = {words_q[rd_base],
                words_q[rd_base + 6'd1],
                words_q[rd_base + 6'd2],
                words_q[rd_base + 6'd3]};
    end
    rd_err = key_ready && (rd_round > NR4);
  end

endmodule

// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xa;
    p  = 8'h00;
    xa = x;
    for (int b = 0; b < 8; b++) begin
      if (y[b]) p = p ^ xa;
      xa = {xa[6:0], 1'b0} ^ (xa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    repeat (7) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  // Inverse then affine transform with constant 0x63.
  always_comb begin
    inv = ginv(a_i);
    s_o = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: AES-128/192/256 instances against a FIPS-197
// key-expansion model built from a table-generated S-box.

module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2:0][255:0] key_v;
  logic [2:0]        key_load_v;
  logic [2:0][3:0]   rd_round_v;
  logic [2:0]        busy_v;
  logic [2:0]        ready_v;
  logic [2:0][127:0] rd_key_v;
  logic [2:0]        rd_err_v;
`ifdef AES_KEYEXP_DEC_EN
  logic [2:0]        rd_dec_v;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_tab [256];
  logic [7:0]  rcon_tab [10];
  logic [31:0] exp_w [60];

  always #5 clk = ~clk;

  aes_key_expander #(.KEY_BITS(128)) u128 (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_v[0][255:128]),
    .key_load  (key_load_v[0]),
    .busy      (busy_v[0]),
    .key_ready (ready_v[0]),
    .rd_round  (rd_round_v[0]),
`ifdef AES_KEYEXP_DEC_EN
    .rd_dec    (rd_dec_v[0]),
`endif
    .rd_key    (rd_key_v[0]),
    .rd_err    (rd_err_v[0])
  );

  aes_key_expander #(.KEY_BITS(192)) u192 (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_v[1][255:64]),
    .key_load  (key_load_v[1]),
    .busy      (busy_v[1]),
    .key_ready (ready_v[1]),
    .rd_round  (rd_round_v[1]),
`ifdef AES_KEYEXP_DEC_EN
    .rd_dec    (rd_dec_v[1]),
`endif
    .rd_key    (rd_key_v[1]),
    .rd_err    (rd_err_v[1])
  );

  aes_key_expander #(.KEY_BITS(256)) u256 (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_v[2]),
    .key_load  (key_load_v[2]),
    .busy      (busy_v[2]),
    .key_ready (ready_v[2]),
    .rd_round  (rd_round_v[2]),
`ifdef AES_KEYEXP_DEC_EN
    .rd_dec    (rd_dec_v[2]),
`endif
    .rd_key    (rd_key_v[2]),
    .rd_err    (rd_err_v[2])
  );

  function automatic void build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]],
            sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Textbook key expansion; key is left-aligned in 256 bits.
  function automatic void build_model(input logic [255:0] key, input int nk);
    int nw;
    logic [31:0] t;
    nw = 4 * (nk + 7);
    for (int i = 0; i < 60; i++) exp_w[i] = 32'h0;
    for (int i = 0; i < nk; i++) exp_w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = exp_w[i-1];
      if (i % nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = sub_word(t);
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endfunction

  function automatic logic [127:0] exp_round(input int r);
    return {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive a one-cycle key_load; returns just after the sampling edge.
  task automatic pulse_load(input int s, input logic [255:0] key);
    @(negedge clk);
    key_v[s] = key;
    key_load_v[s] = 1'b1;
    @(negedge clk);
    key_load_v[s] = 1'b0;
  endtask

  // Edges from the sampling edge until key_ready (200 = timeout).
  task automatic wait_ready(input int s, output int lat);
    lat = 0;
    while (!ready_v[s] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      rd_round_v[s] = 4'd0;
      #1;
      checks++;
      if ({busy_v[s], ready_v[s], rd_err_v[s]} !== 3'b000 ||
          rd_key_v[s] !== 128'h0) begin
        errors++;
        $display("FAIL reset s=%0d got busy=%b rdy=%b err=%b key=%h exp all 0",
                 s, busy_v[s], ready_v[s], rd_err_v[s], rd_key_v[s]);
      end
    end
  endtask

  task automatic test_fips();
    logic [255:0] k [3];
    logic [127:0] kat;
    int lat;
    int nk;
    int r;
    k[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    for (int s = 0; s < 3; s++) begin
      nk = 4 + 2 * s;
      build_model(k[s], nk);
      pulse_load(s, k[s]);
      wait_ready(s, lat);
      checks++;
      if (lat != 4 * (nk + 7) - nk) begin
        errors++;
        $display("FAIL fips_latency s=%0d got %0d exp %0d", s, lat, 4*(nk+7)-nk);
      end
      for (int j = 0; j < 3; j++) begin
        case (s)
          0: begin
            r = (j == 0) ? 0 : (j == 1) ? 1 : 10;
            kat = (j == 0) ? 128'h2b7e151628aed2a6abf7158809cf4f3c :
                  (j == 1) ? 128'ha0fafe1788542cb123a339392a6c7605 :
                             128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
          end
          1: begin
            r = 12;
            kat = 128'he98ba06f448c773c8ecc720401002202;
          end
          default: begin
            r = 14;
            kat = 128'hfe4890d1e6188d0b046df344706c631e;
          end
        endcase
        rd_round_v[s] = 4'(r);
        #1;
        checks++;
        if (rd_key_v[s] !== kat || rd_err_v[s] !== 1'b0) begin
          errors++;
          $display("FAIL fips_kat s=%0d r=%0d got %h err=%b exp %h err=0",
                   s, r, rd_key_v[s], rd_err_v[s], kat);
        end
      end
      for (int rr = 0; rr <= nk + 6; rr++) begin
        rd_round_v[s] = 4'(rr);
        #1;
        checks++;
        if (rd_key_v[s] !== exp_round(rr)) begin
          errors++;
          $display("FAIL fips_sched s=%0d r=%0d got %h exp %h",
                   s, rr, rd_key_v[s], exp_round(rr));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] key;
    int lat;
    int nk;
    for (int s = 0; s < 3; s++) begin
      nk = 4 + 2 * s;
      for (int n = 0; n < 3; n++) begin
        key = rand_key();
        build_model(key, nk);
        pulse_load(s, key);
        wait_ready(s, lat);
        checks++;
        if (lat != 4 * (nk + 7) - nk) begin
          errors++;
          $display("FAIL rand_latency s=%0d got %0d exp %0d", s, lat, 4*(nk+7)-nk);
        end
        for (int rr = 0; rr <= nk + 6; rr++) begin
          rd_round_v[s] = 4'(rr);
          #1;
          checks++;
          if (rd_key_v[s] !== exp_round(rr) || rd_err_v[s] !== 1'b0) begin
            errors++;
            $display("FAIL rand_sched s=%0d r=%0d got %h err=%b exp %h err=0",
                     s, rr, rd_key_v[s], rd_err_v[s], exp_round(rr));
          end
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    int nr;
    for (int s = 0; s < 3; s++) begin
      nr = 10 + 2 * s;
      for (int r = nr; r < 16; r++) begin
        rd_round_v[s] = 4'(r);
        #1;
        checks++;
        if (r == nr) begin
          if (rd_err_v[s] !== 1'b0 || rd_key_v[s] === 128'h0) begin
            errors++;
            $display("FAIL range_edge s=%0d r=%0d got err=%b key=%h exp err=0 key!=0",
                     s, r, rd_err_v[s], rd_key_v[s]);
          end
        end else if (rd_err_v[s] !== 1'b1 || rd_key_v[s] !== 128'h0) begin
          errors++;
          $display("FAIL range_oob s=%0d r=%0d got err=%b key=%h exp err=1 key=0",
                   s, r, rd_err_v[s], rd_key_v[s]);
        end
      end
    end
  endtask

  task automatic test_before_complete();
    int s;
    s = 2;
    pulse_load(s, rand_key());
    for (int c = 0; c < 52; c++) begin
      rd_round_v[s] = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if ({busy_v[s], ready_v[s], rd_err_v[s]} !== 3'b100 ||
          rd_key_v[s] !== 128'h0) begin
        errors++;
        $display("FAIL pending c=%0d r=%0d got busy=%b rdy=%b err=%b key=%h exp 1/0/0 key=0",
                 c, rd_round_v[s], busy_v[s], ready_v[s], rd_err_v[s], rd_key_v[s]);
      end
      @(negedge clk);
    end
    checks++;
    if (busy_v[s] !== 1'b0 || ready_v[s] !== 1'b1) begin
      errors++;
      $display("FAIL done_edge got busy=%b rdy=%b exp busy=0 rdy=1",
               busy_v[s], ready_v[s]);
    end
  endtask

  task automatic test_abort_reload();
    logic [255:0] ka;
    logic [255:0] kb;
    int lat;
    ka = rand_key();
    kb = rand_key();
    pulse_load(0, ka);
    repeat (19) @(negedge clk);
    pulse_load(0, kb);
    wait_ready(0, lat);
    checks++;
    if (lat != 40) begin
      errors++;
      $display("FAIL reload_latency got %0d exp 40", lat);
    end
    build_model(kb, 4);
    for (int rr = 0; rr <= 10; rr++) begin
      rd_round_v[0] = 4'(rr);
      #1;
      checks++;
      if (rd_key_v[0] !== exp_round(rr)) begin
        errors++;
        $display("FAIL reload_sched r=%0d got %h exp %h", rr, rd_key_v[0], exp_round(rr));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] k3;
    int lat;
    k3 = rand_key();
    @(negedge clk);
    key_load_v[0] = 1'b1;
    key_v[0] = rand_key();
    @(negedge clk);
    key_v[0] = rand_key();
    @(negedge clk);
    key_v[0] = k3;
    @(negedge clk);
    key_load_v[0] = 1'b0;
    wait_ready(0, lat);
    checks++;
    if (lat != 40) begin
      errors++;
      $display("FAIL held_latency got %0d exp 40", lat);
    end
    build_model(k3, 4);
    for (int rr = 0; rr <= 10; rr++) begin
      rd_round_v[0] = 4'(rr);
      #1;
      checks++;
      if (rd_key_v[0] !== exp_round(rr)) begin
        errors++;
        $display("FAIL held_sched r=%0d got %h exp %h", rr, rd_key_v[0], exp_round(rr));
      end
    end
  endtask

  task automatic test_reset_abort();
    pulse_load(0, rand_key());
    repeat (19) @(negedge clk);
    rst = 1'b1;
    for (int rr = 0; rr < 12; rr += 11) begin
      rd_round_v[0] = 4'(rr);
      #1;
      checks++;
      if ({busy_v[0], ready_v[0], rd_err_v[0]} !== 3'b000 ||
          rd_key_v[0] !== 128'h0) begin
        errors++;
        $display("FAIL rst_abort r=%0d got busy=%b rdy=%b err=%b key=%h exp all 0",
                 rr, busy_v[0], ready_v[0], rd_err_v[0], rd_key_v[0]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    rd_round_v[0] = 4'd0;
    #1;
    checks++;
    if ({busy_v[0], ready_v[0]} !== 2'b00 || rd_key_v[0] !== 128'h0) begin
      errors++;
      $display("FAIL rst_idle got busy=%b rdy=%b key=%h exp idle key=0",
               busy_v[0], ready_v[0], rd_key_v[0]);
    end
  endtask

`ifdef AES_KEYEXP_DEC_EN
  task automatic test_dec();
    logic [255:0] k;
    int lat;
    k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    build_model(k, 4);
    pulse_load(0, k);
    wait_ready(0, lat);
    rd_dec_v[0] = 1'b1;
    rd_round_v[0] = 4'd0;
    #1;
    checks++;
    if (rd_key_v[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL dec_kat got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key_v[0]);
    end
    for (int rr = 1; rr <= 11; rr++) begin
      rd_round_v[0] = 4'(rr);
      #1;
      checks++;
      if (rr == 11) begin
        if (rd_key_v[0] !== 128'h0 || rd_err_v[0] !== 1'b1) begin
          errors++;
          $display("FAIL dec_oob got %h err=%b exp 0 err=1", rd_key_v[0], rd_err_v[0]);
        end
      end else if (rd_key_v[0] !== exp_round(10 - rr)) begin
        errors++;
        $display("FAIL dec_sched r=%0d got %h exp %h", rr, rd_key_v[0], exp_round(10-rr));
      end
    end
    rd_dec_v[0] = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    key_v      = '0;
    key_load_v = '0;
    rd_round_v = '0;
`ifdef AES_KEYEXP_DEC_EN
    rd_dec_v   = '0;
`endif
    build_sbox();
    test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_fips();
    test_random();
    test_out_of_range();
    test_before_complete();
    test_abort_reload();
    test_back_to_back();
    test_reset_abort();
`ifdef AES_KEYEXP_DEC_EN
    test_dec();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Parametrised AES key-schedule engine supporting AES-128, AES-192 and AES-256. It expands a cipher key into the full round-key schedule, one 32-bit word per cycle, using a single shared four-S-box SubWord unit. It stores the schedule and serves any round key through a combinational random-access read port. It sits between the key receive shift register and the round datapath (pre-add and add-round-key stages), and is the generalised successor of the fixed-width 128-bit round-key generator.

## Interface
- KEY_BITS, 128: cipher key width; legal values are 128, 192 and 256, and any other value is an elaboration error. Derived values:
  - NK = KEY_BITS/32
  - NR = NK+6
  - NW = 4*(NR+1), giving 44, 52 or 60 words
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- key_in  input  KEY_BITS  cipher key; word w[0] = key_in[KEY_BITS-1 -: 32].
- key_load  input  1  single-cycle request to capture key_in and start expansion.
- busy  output  1  expansion in progress.
- key_ready  output  1  the full schedule for the last loaded key is valid.
- rd_round  input  4  round index requested.
- rd_key  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].
- rd_err  output  1  rd_round > NR while key_ready=1.

## Operation
- FSM states are IDLE, EXPAND and READY.
- IDLE:
  - key_load=1 → capture w[0..NK-1] from key_in, set index i=NK, set rcon=0x01, go to EXPAND.
- EXPAND: write one word per cycle, with temp = w[i-1]:
  - i mod NK == 0: w[i] = w[i-NK] ^ SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon ← xtime(rcon). The xtime sequence is 01,02,04,08,10,20,40,80,1b,36.
  - NK==8 and i mod NK == 4: w[i] = w[i-NK] ^ SubWord(temp).
  - Otherwise: w[i] = w[i-NK] ^ temp.
  - Track i mod NK with a wrap counter; no divider is used.
  - After writing w[NW-1], go to READY.
- READY:
  - Hold the schedule.
  - key_load=1 → recapture the key and go to EXPAND (the same action as in IDLE).
- key_load in EXPAND aborts the current expansion and restarts with the new key_in. key_ready stays 0.
- RotWord rotates left by one byte. SubWord applies the AES S-box to each of the four bytes using the existing S-box module, with 4 instances.
- Read port is purely combinational:
  - key_ready=1 and rd_round ≤ NR → rd_key = round key rd_round.
  - Otherwise rd_key = 0.
  - rd_err = key_ready & (rd_round > NR).
- All storage is overwritten only by a load or an expansion write. A partially expanded schedule is never visible.

## Timing
- Reset (rst=1, asynchronous): state=IDLE; busy=0; key_ready=0; rd_key=0; rd_err=0; all words cleared; rcon=0x01.
- key_load sampled at edge E:
  - busy=1 and key_ready=0 from E+1.
  - Final word written at edge E+(NW-NK), i.e. E+40, E+46 or E+52.
  - busy falls and key_ready rises at that same edge.
- Expansion latency is 40, 46 or 52 cycles for AES-128, AES-192 and AES-256, independent of rd_round activity.
- key_load held high for several cycles restarts on each cycle. The schedule completes NW-NK cycles after the last high sample.
- rst asserted mid-expansion returns to IDLE immediately. No output glitches to a partial key.
- rd_key and rd_err follow rd_round in the same cycle, with no register.

## Configuration
- AES_KEYEXP_DEC_EN defined:
  - Adds input rd_dec (1 bit).
  - When rd_dec=1, the read port returns round key NR-rd_round, serving the decryption order. rd_err is still based on rd_round > NR.
- Undefined: rd_dec is absent and reads are always in forward order.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, load → key_ready exactly 40 cycles later:
  - round 0 = the key
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → key_ready after 46 cycles; round 12 = e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → key_ready after 52 cycles; round 14 = fe4890d1e6188d0b046df344706c631e.
- Reads out of range and before completion:
  - AES-128 with rd_round=11 after completion → rd_key=0, rd_err=1.
  - Any rd_round before completion → rd_key=0, rd_err=0.
- Abort by reload and by reset:
  - AES-128 load key A; at cycle 20 load key B → key_ready 40 cycles after the B load, and the schedule matches B only.
  - Repeat with rst pulsed at cycle 20 → all outputs 0, IDLE.
- With AES_KEYEXP_DEC_EN defined, AES-128 FIPS key, rd_dec=1, rd_round=0 → rd_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
